mmio_seg_display: RTL and testbench

//  Memory-mapped N-digit multiplexed 7-segment display controller for the SoC data bus.

---
 rtl/mmio_seg_display.sv | 140 ++++++++++++++
 tb/tb_mmio_seg_display.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_seg_display.sv
// mmio_seg_display
//   Memory-mapped multiplexed 7-segment display controller. Snoops the core's
//   write port, holds a DATA register (one hex nibble per digit) and a CTRL
//   register (brightness, enable, leading-zero blanking, decimal-point mask),
//   and scans the digits with a per-slot brightness PWM.
// Ports
//   clk         clock
//   rst_n       synchronous active-low reset
//   bus_w_en    bus write strobe, one cycle per write
//   bus_w_addr  bus byte address, bits [1:0] ignored
//   bus_w_data  bus write data
//   seg_sel     one-hot digit enable, active high, all zero = dark
//   seg_driver  segments {dp,g,f,e,d,c,b,a}, active low
//   disp_value  current DATA register contents
module mmio_seg_display #(
  parameter int                 DIGITS    = 4,
  parameter int                 ADDR_W    = 32,
  parameter int                 DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 'h0000_1000,
  parameter int                 SCAN_DIV  = 1024,
  parameter int                 BRIGHT_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus_w_en,
  input  logic [ADDR_W-1:0]     bus_w_addr,
  input  logic [DATA_W-1:0]     bus_w_data,
  output logic [DIGITS-1:0]     seg_sel,
  output logic [7:0]            seg_driver,
  output logic [4*DIGITS-1:0]   disp_value
);

  localparam int NW      = 4 * DIGITS;
  localparam int PW      = $clog2(SCAN_DIV);
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SUB_DIV = SCAN_DIV >> BRIGHT_W;

  localparam logic [PW-1:0]       PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]       SUB_DIV_W  = PW'(SUB_DIV);
  localparam logic [IW-1:0]       IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [ADDR_W-3:0]   DATA_WORD  = BASE_ADDR[ADDR_W-1:2];
  localparam logic [ADDR_W-3:0]   CTRL_WORD  = DATA_WORD + (ADDR_W-2)'(1);

  // Standard hex to gfedcba decode, active high.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [ADDR_W-3:0]   word_addr;
  logic                wr_data;
  logic                wr_ctrl;
  logic                unused_bits;

  logic [NW-1:0]       data_q;
  logic [BRIGHT_W-1:0] bright_q;
  logic                en_q;
  logic                lzb_q;
  logic [DIGITS-1:0]   dp_q;

  logic [PW-1:0]       presc_p0;
  logic [IW-1:0]       idx_p0;

  logic [DIGITS-1:0]   onehot;
  logic [3:0]          nibble;
  logic [PW-1:0]       sub_full;
  logic                blanked;
  logic                dp_bit;
  logic                lit;

  assign word_addr   = bus_w_addr[ADDR_W-1:2];
  assign wr_data     = bus_w_en && (word_addr == DATA_WORD);
  assign wr_ctrl     = bus_w_en && (word_addr == CTRL_WORD);
  // Byte-lane address bits and undecoded data bits are intentionally dropped.
  assign unused_bits = ^{bus_w_addr[1:0], bus_w_data};
  assign disp_value  = data_q;

  // ---- register file: DATA / CTRL ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q   <= '0;
      bright_q <= '1;
      en_q     <= 1'b1;
      lzb_q    <= 1'b0;
      dp_q     <= '0;
    end else begin
      if (wr_data) data_q <= bus_w_data[NW-1:0];
      if (wr_ctrl) begin
        bright_q <= bus_w_data[BRIGHT_W-1:0];
        en_q     <= bus_w_data[8];
        lzb_q    <= bus_w_data[9];
        dp_q     <= bus_w_data[16 +: DIGITS];
      end
    end
  end

  // ---- stage p0: prescaler and digit index ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_p0 <= '0;
      idx_p0   <= '0;
    end else if (presc_p0 == PRESC_LAST) begin
      presc_p0 <= '0;
      idx_p0   <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IW'(1);
    end else begin
      presc_p0 <= presc_p0 + PW'(1);
    end
  end

  always_comb begin
    onehot   = DIGITS'(1) << idx_p0;
    nibble   = 4'(data_q >> (4 * idx_p0));
    sub_full = presc_p0 / SUB_DIV_W;
    dp_bit   = |(dp_q & onehot);
    // A digit above 0 is blank when it and every more-significant nibble is zero.
    blanked  = lzb_q && (idx_p0 != '0) && ((data_q >> (4 * idx_p0)) == '0);
    lit      = en_q && (sub_full <= PW'(bright_q)) && !blanked;
  end

  // ---- stage p1: registered display outputs ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_sel    <= '0;
      seg_driver <= 8'hFF;
    end else if (lit) begin
      seg_sel    <= onehot;
      seg_driver <= {~dp_bit, ~hex7(nibble)};
    end else begin
      seg_sel    <= '0;
      seg_driver <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_mmio_seg_display.sv
// tb_mmio_seg_display
//   Directed and randomized stimulus for mmio_seg_display (DIGITS=4,
//   SCAN_DIV=16, BRIGHT_W=2). Expected outputs come from a time-based model:
//   the scan position is derived from the number of clock edges since reset.
module tb_mmio_seg_display;

  localparam int          DIGITS   = 4;
  localparam int          SCAN_DIV = 16;
  localparam int          BRIGHT_W = 2;
  localparam logic [31:0] BASE     = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic        bus_w_en;
  logic [31:0] bus_w_addr;
  logic [31:0] bus_w_data;
  logic [3:0]  seg_sel;
  logic [7:0]  seg_driver;
  logic [15:0] disp_value;

  mmio_seg_display #(
    .DIGITS(DIGITS), .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE),
    .SCAN_DIV(SCAN_DIV), .BRIGHT_W(BRIGHT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_w_en(bus_w_en), .bus_w_addr(bus_w_addr),
    .bus_w_data(bus_w_data), .seg_sel(seg_sel), .seg_driver(seg_driver),
    .disp_value(disp_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic [15:0] m_data;
  logic [31:0] m_ctrl;
  int          m_t;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [11:0] ref_out(input logic [15:0] d, input logic [31:0] c, input int t);
    int idx, sub, bright, nib, upper;
    bit en, lz, blank, lit, dp;
    logic [3:0] sel;
    logic [7:0] drv;
    idx    = (t / SCAN_DIV) % DIGITS;
    sub    = (t % SCAN_DIV) / (SCAN_DIV / (1 << BRIGHT_W));
    bright = int'(c[1:0]);
    en     = c[8];
    lz     = c[9];
    dp     = c[16 + idx];
    nib    = (int'(d) >> (4 * idx)) & 15;
    upper  = int'(d) >> (4 * idx);
    blank  = lz && (idx > 0) && (upper == 0);
    lit    = en && (sub <= bright) && !blank;
    if (lit) begin
      sel = 4'(1 << idx);
      drv = {~dp, ~seg_tab[nib]};
    end else begin
      sel = 4'h0;
      drv = 8'hFF;
    end
    return {sel, drv};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h (t=%0d)", tag, got, exp, m_t);
    end
  endtask

  // One clock edge: compute expectation from pre-edge model, update model, compare.
  task automatic tick();
    logic [11:0] e;
    logic [31:0] w;
    @(posedge clk);
    if (!rst_n) begin
      e      = {4'h0, 8'hFF};
      m_data = 16'h0;
      m_ctrl = 32'h0000_0103;
      m_t    = 0;
    end else begin
      e = ref_out(m_data, m_ctrl, m_t);
      if (bus_w_en) begin
        w = bus_w_addr >> 2;
        if (w == (BASE >> 2))           m_data = bus_w_data[15:0];
        else if (w == (BASE >> 2) + 1)  m_ctrl = bus_w_data;
      end
      m_t++;
    end
    #1;
    check("seg_sel", 32'(seg_sel), 32'(e[11:8]));
    check("seg_driver", 32'(seg_driver), 32'(e[7:0]));
    check("disp_value", 32'(disp_value), 32'(m_data));
    n_tests++;
    assert ($countones(seg_sel) <= 1) else begin
      n_fail++;
      $error("FAIL onehot got=%b exp=at most one bit", seg_sel);
    end
    @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bus_w_en   = 1'b1;
    bus_w_addr = a;
    bus_w_data = d;
    tick();
    bus_w_en   = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          k;
    rst_n      = 1'b0;
    bus_w_en   = 1'b0;
    bus_w_addr = 32'h0;
    bus_w_data = 32'h0;
    m_data     = 16'h0;
    m_ctrl     = 32'h0000_0103;
    m_t        = 0;

    // 1. reset, then digit 0 shows "0"
    run(3);
    rst_n = 1'b1;
    tick();
    check("rel_sel", 32'(seg_sel), 32'h1);
    check("rel_drv", 32'(seg_driver), 32'hC0);
    run(20);

    // 2. hex digits walk across the display
    do_write(BASE, 32'h0000_1A2F);
    run(70);

    // 3. half brightness, then disable
    do_write(BASE + 4, 32'h0000_0101);
    run(64);
    do_write(BASE + 4, 32'h0000_0001);
    run(20);

    // 4. leading-zero blanking on and off
    do_write(BASE, 32'h0000_0005);
    do_write(BASE + 4, 32'h0000_0303);
    run(64);
    do_write(BASE + 4, 32'h0000_0103);
    run(64);

    // 5. out-of-window writes ignored, decimal point on digit 1
    do_write(BASE + 8, 32'hFFFF_FFFF);
    do_write(BASE - 4, 32'hFFFF_FFFF);
    check("oow_disp", 32'(disp_value), 32'h0005);
    do_write(BASE + 4, 32'h0002_0103);
    do_write(BASE + 3, 32'h0000_1234);
    run(64);

    // 6. reset mid-slot while digit 2 is lit
    k = 0;
    while (!(((m_t / SCAN_DIV) % DIGITS == 2) && (m_t % SCAN_DIV == 5)) && k < 80) begin
      tick();
      k++;
    end
    check("reach_digit2", 32'(k < 80), 32'h1);
    tick();
    check("pre_rst_sel", 32'(seg_sel), 32'h4);
    rst_n = 1'b0;
    tick();
    check("mid_rst_disp", 32'(disp_value), 32'h0);
    check("mid_rst_drv", 32'(seg_driver), 32'hFF);
    rst_n = 1'b1;
    tick();
    check("restart_sel", 32'(seg_sel), 32'h1);
    check("restart_drv", 32'(seg_driver), 32'hC0);
    run(40);

    // 7. randomized writes and occasional resets
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       a = BASE;
          1:       a = BASE + 4;
          2:       a = BASE + 8;
          default: a = BASE - 4;
        endcase
        a[1:0] = 2'($urandom_range(0, 3));
        d      = $urandom;
        d[8]   = ($urandom_range(0, 3) != 0);
        do_write(a, d);
      end else begin
        tick();
      end
    end
    rst_n = 1'b1;
    run(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
